// File: rtl/dsp_mac_slice.sv
// dsp_mac_slice: signed pre-add / multiply / accumulate slice with cascade,
// global stall, optional M register and saturating or wrapping accumulation.
module dsp_mac_slice #(
    parameter int AW       = 18,
    parameter int BW       = 18,
    parameter int PW       = 48,
    parameter int PIPE_M   = 1,
    parameter int SATURATE = 1
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          CE,
    input  logic          IN_VALID,
    input  logic [AW-1:0] A,
    input  logic [BW-1:0] B,
    input  logic [BW-1:0] D,
    input  logic [PW-1:0] C,
    input  logic [PW-1:0] PCIN,
    input  logic [4:0]    OPMODE,
    input  logic          CLR_OVF,
    output logic [PW-1:0] P,
    output logic [PW-1:0] PCOUT,
    output logic          OUT_VALID,
    output logic          OVF
);

    localparam int MW = AW + BW + 1;

    logic [BW:0]   w_d_ext;
    logic [BW:0]   w_b_ext;
    logic [BW:0]   w_pre;
    logic [BW:0]   w_b1_next;

    logic [AW-1:0] r_a1;
    logic [BW:0]   r_b1;
    logic [PW-1:0] r_c1;
    logic [2:0]    r_op1;
    logic          r_v1;

    logic [MW-1:0] w_m;
    logic [MW-1:0] w_m3;
    logic [PW-1:0] w_c3;
    logic [2:0]    w_op3;
    logic          w_v3;

    logic [PW-1:0] w_z;
    logic [PW:0]   w_z_ext;
    logic [PW:0]   w_m_ext;
    logic [PW:0]   w_s;
    logic          w_ovf;
    logic [PW-1:0] w_sat;
    logic [PW-1:0] w_p_next;

    logic [PW-1:0] r_p;
    logic          r_valid;
    logic          r_ovf;

    assign w_d_ext   = {D[BW-1], D};
    assign w_b_ext   = {B[BW-1], B};
    assign w_pre     = OPMODE[1] ? (w_d_ext - w_b_ext) : (w_d_ext + w_b_ext);
    assign w_b1_next = OPMODE[0] ? w_pre : w_b_ext;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_a1  <= '0;
            r_b1  <= '0;
            r_c1  <= '0;
            r_op1 <= '0;
            r_v1  <= 1'b0;
        end else if (CE) begin
            r_a1  <= A;
            r_b1  <= w_b1_next;
            r_c1  <= C;
            r_op1 <= OPMODE[4:2];
            r_v1  <= IN_VALID;
        end
    end

    assign w_m = $signed(r_a1) * $signed(r_b1);

    generate
        if (PIPE_M != 0) begin : g_mreg
            logic [MW-1:0] r_m2;
            logic [PW-1:0] r_c2;
            logic [2:0]    r_op2;
            logic          r_v2;

            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    r_m2  <= '0;
                    r_c2  <= '0;
                    r_op2 <= '0;
                    r_v2  <= 1'b0;
                end else if (CE) begin
                    r_m2  <= w_m;
                    r_c2  <= r_c1;
                    r_op2 <= r_op1;
                    r_v2  <= r_v1;
                end
            end

            assign w_m3  = r_m2;
            assign w_c3  = r_c2;
            assign w_op3 = r_op2;
            assign w_v3  = r_v2;
        end else begin : g_mcomb
            assign w_m3  = w_m;
            assign w_c3  = r_c1;
            assign w_op3 = r_op1;
            assign w_v3  = r_v1;
        end
    endgenerate

    always_comb begin
        w_z = '0;
        unique case (w_op3[1:0])
            2'd0: w_z = '0;
            2'd1: w_z = w_c3;
            2'd2: w_z = r_p;
            2'd3: w_z = PCIN;
        endcase
    end

    // One guard bit: the sum of two PW-bit signed values always fits PW+1.
    assign w_z_ext = {w_z[PW-1], w_z};
    assign w_m_ext = {{(PW + 1 - MW){w_m3[MW-1]}}, w_m3};
    assign w_s     = w_op3[2] ? (w_z_ext - w_m_ext) : (w_z_ext + w_m_ext);
    assign w_ovf   = w_s[PW] ^ w_s[PW-1];
    assign w_sat   = w_s[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    assign w_p_next = (w_ovf && (SATURATE != 0)) ? w_sat : w_s[PW-1:0];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_p     <= '0;
            r_valid <= 1'b0;
        end else if (CE) begin
            r_valid <= w_v3;
            if (w_v3) begin
                r_p <= w_p_next;
            end
        end
    end

    // A fresh overflow wins over a simultaneous clear.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_ovf <= 1'b0;
        end else if (CE && w_v3 && w_ovf) begin
            r_ovf <= 1'b1;
        end else if (CLR_OVF) begin
            r_ovf <= 1'b0;
        end
    end

    assign P         = r_p;
    assign PCOUT     = r_p;
    assign OUT_VALID = r_valid;
    assign OVF       = r_ovf;

endmodule
